// File: rtl/width_adapter_if.sv
// Stream bus shared by the width adapter and its neighbours: input beat side plus output word side.
// Latency: none, wiring only.
// Backpressure: carries in_ready/out_ready; the adapter uses 'slave', the environment uses 'master'.
//
// Ports (as seen by the adapter through 'slave'):
//   in_valid/in_data/in_last -> in   input beat, in_ready <- out
//   out_valid/out_data/out_keep/out_last -> out   output word, out_ready <- in
interface width_adapter_if #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32
);
    localparam int MIN_W = (IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
    localparam int KW    = OUT_WIDTH / MIN_W;

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [KW-1:0]        out_keep;
    logic                 out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/width_adapter.sv
// Packs narrow beats into wide words (UP), unpacks wide words into narrow slices (DOWN), or registers 1:1 (PASS).
// Latency: 1 cycle from the completing input beat (UP/PASS) or accepted word (DOWN) to out_valid.
// Backpressure: outputs hold stable while out_valid && !out_ready; in_ready drops instead of dropping data.
//
// Ports: clk (rising edge), rst (synchronous, active high), bus (width_adapter_if.slave),
//        busy (partial word being assembled, word being sliced, or output word pending).
module width_adapter #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    width_adapter_if.slave bus,
    output logic           busy
);
    localparam int MIN_W = (IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
    localparam int MAX_W = (IN_WIDTH < OUT_WIDTH) ? OUT_WIDTH : IN_WIDTH;
    localparam int R     = MAX_W / MIN_W;
    localparam int KW    = OUT_WIDTH / MIN_W;
    localparam int CW    = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(R - 1);

    if ((MAX_W % MIN_W) != 0) begin : g_bad_widths
        $error("width_adapter: wider port width must be an integer multiple of the narrower one");
    end

    logic                 w_in_ready;
    logic                 w_out_valid;
    logic [OUT_WIDTH-1:0] w_out_data;
    logic [KW-1:0]        w_out_keep;
    logic                 w_out_last;
    logic                 w_busy;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.out_keep  = w_out_keep;
    assign bus.out_last  = w_out_last;
    assign busy          = w_busy;

    if (IN_WIDTH <= OUT_WIDTH) begin : g_up
        // PASS is the degenerate R=1 case: every beat completes a single-lane word.
        logic [OUT_WIDTH-1:0] r_acc;
        logic [KW-1:0]        r_acc_keep;
        logic [CW-1:0]        r_cnt;
        logic [OUT_WIDTH-1:0] r_out_data;
        logic [KW-1:0]        r_out_keep;
        logic                 r_out_last;
        logic                 r_out_valid;
        logic                 w_in_fire;
        logic                 w_out_fire;
        logic                 w_complete;
        logic [OUT_WIDTH-1:0] w_word;
        logic [KW-1:0]        w_word_keep;

        // Gated by rst so nothing is offered to the source while in reset.
        assign w_in_ready = !rst && !(r_out_valid && !bus.out_ready);
        assign w_in_fire  = bus.in_valid && w_in_ready;
        assign w_out_fire = r_out_valid && bus.out_ready;
        assign w_complete = (r_cnt == LAST_IDX) || bus.in_last;

        // Accumulator lanes above r_cnt are always zero, so merging the incoming
        // beat yields the finished word with unfilled lanes already cleared.
        always_comb begin
            w_word                       = r_acc;
            w_word_keep                  = r_acc_keep;
            w_word[r_cnt*MIN_W +: MIN_W] = bus.in_data;
            w_word_keep[r_cnt]           = 1'b1;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_acc       <= '0;
                r_acc_keep  <= '0;
                r_cnt       <= '0;
                r_out_data  <= '0;
                r_out_keep  <= '0;
                r_out_last  <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_out_fire) begin
                    r_out_valid <= 1'b0;
                end
                // A load can coincide with the transfer of the previous word.
                if (w_in_fire) begin
                    if (w_complete) begin
                        r_out_data  <= w_word;
                        r_out_keep  <= w_word_keep;
                        r_out_last  <= bus.in_last;
                        r_out_valid <= 1'b1;
                        r_acc       <= '0;
                        r_acc_keep  <= '0;
                        r_cnt       <= '0;
                    end else begin
                        r_acc      <= w_word;
                        r_acc_keep <= w_word_keep;
                        r_cnt      <= r_cnt + CW'(1);
                    end
                end
            end
        end

        assign w_out_valid = r_out_valid;
        assign w_out_data  = r_out_data;
        assign w_out_keep  = r_out_keep;
        assign w_out_last  = r_out_last;
        assign w_busy      = r_out_valid || (r_cnt != '0);
    end else begin : g_down
        logic [IN_WIDTH-1:0] r_shift;
        logic [CW-1:0]       r_s;
        logic                r_held;
        logic                r_word_last;
        logic                w_in_fire;
        logic                w_out_fire;
        logic                w_slice_end;

        assign w_slice_end = (r_s == LAST_IDX);
        // Taking a new word on the same edge the final slice leaves avoids a bubble.
        assign w_in_ready  = !rst && (!r_held || (bus.out_ready && w_slice_end));
        assign w_in_fire   = bus.in_valid && w_in_ready;
        assign w_out_fire  = r_held && bus.out_ready;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_shift     <= '0;
                r_s         <= '0;
                r_held      <= 1'b0;
                r_word_last <= 1'b0;
            end else if (w_in_fire) begin
                r_shift     <= bus.in_data;
                r_s         <= '0;
                r_held      <= 1'b1;
                r_word_last <= bus.in_last;
            end else if (w_out_fire) begin
                if (w_slice_end) begin
                    r_held <= 1'b0;
                    r_s    <= '0;
                end else begin
                    // Slice s always sits in the low bits of the shift register.
                    r_shift <= r_shift >> OUT_WIDTH;
                    r_s     <= r_s + CW'(1);
                end
            end
        end

        assign w_out_valid = r_held;
        assign w_out_data  = r_shift[OUT_WIDTH-1:0];
        assign w_out_keep  = {KW{r_held}};
        assign w_out_last  = r_held && r_word_last && w_slice_end;
        assign w_busy      = r_held;
    end
endmodule

// File: tb/tb_width_adapter.sv
// Self-checking bench for width_adapter in UP (8->32), DOWN (32->8) and PASS (16->16) configurations.
// Latency: n/a.
// Backpressure: random out_ready toggling on every configuration.
module tb_width_adapter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    width_adapter_if #(.IN_WIDTH(8),  .OUT_WIDTH(32)) up_if ();
    width_adapter_if #(.IN_WIDTH(32), .OUT_WIDTH(8))  dn_if ();
    width_adapter_if #(.IN_WIDTH(16), .OUT_WIDTH(16)) ps_if ();
    logic up_busy, dn_busy, ps_busy;

    width_adapter #(.IN_WIDTH(8),  .OUT_WIDTH(32)) u_up (.clk(clk), .rst(rst), .bus(up_if.slave), .busy(up_busy));
    width_adapter #(.IN_WIDTH(32), .OUT_WIDTH(8))  u_dn (.clk(clk), .rst(rst), .bus(dn_if.slave), .busy(dn_busy));
    width_adapter #(.IN_WIDTH(16), .OUT_WIDTH(16)) u_ps (.clk(clk), .rst(rst), .bus(ps_if.slave), .busy(ps_busy));

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        iv;
        logic [31:0] din;
        logic        il;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_dat;
        logic [3:0]  e_keep;
        logic        e_last;
        logic        e_busy;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    vec_t up_tab[14];
    vec_t dn_tab[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] din, input logic il, input logic ordy,
                                input logic e_ir, input logic e_ov, input logic [31:0] e_dat,
                                input logic [3:0] e_keep, input logic e_last, input logic e_busy);
        vec_t v;
        v.iv = iv; v.din = din; v.il = il; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_dat = e_dat; v.e_keep = e_keep; v.e_last = e_last; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic drive(input int sel, input logic iv, input logic [31:0] d, input logic l, input logic ordy);
        case (sel)
            0: begin up_if.in_valid = iv; up_if.in_data = d[7:0];  up_if.in_last = l; up_if.out_ready = ordy; end
            1: begin dn_if.in_valid = iv; dn_if.in_data = d;       dn_if.in_last = l; dn_if.out_ready = ordy; end
            default: begin ps_if.in_valid = iv; ps_if.in_data = d[15:0]; ps_if.in_last = l; ps_if.out_ready = ordy; end
        endcase
    endtask

    task automatic idle_all();
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic sample(input int sel, output logic ir, output logic ov, output logic [31:0] od,
                          output logic [3:0] ok, output logic ol, output logic bz);
        case (sel)
            0: begin ir = up_if.in_ready; ov = up_if.out_valid; od = up_if.out_data;
                     ok = up_if.out_keep; ol = up_if.out_last; bz = up_busy; end
            1: begin ir = dn_if.in_ready; ov = dn_if.out_valid; od = {24'h0, dn_if.out_data};
                     ok = {3'b0, dn_if.out_keep}; ol = dn_if.out_last; bz = dn_busy; end
            default: begin ir = ps_if.in_ready; ov = ps_if.out_valid; od = {16'h0, ps_if.out_data};
                     ok = {3'b0, ps_if.out_keep}; ol = ps_if.out_last; bz = ps_busy; end
        endcase
    endtask

    task automatic run_table(input int sel, input string tag, input vec_t tab[]);
        logic ir, ov, ol, bz;
        logic [31:0] od;
        logic [3:0] ok;
        for (int i = 0; i < tab.size(); i++) begin
            @(negedge clk);
            drive(sel, tab[i].iv, tab[i].din, tab[i].il, tab[i].ordy);
            #1;
            sample(sel, ir, ov, od, ok, ol, bz);
            chk($sformatf("%s[%0d].in_ready", tag, i), ir, tab[i].e_ir);
            chk($sformatf("%s[%0d].out_valid", tag, i), ov, tab[i].e_ov);
            chk($sformatf("%s[%0d].busy", tag, i), bz, tab[i].e_busy);
            if (tab[i].e_ov) begin
                chk($sformatf("%s[%0d].out_data", tag, i), od, tab[i].e_dat);
                chk($sformatf("%s[%0d].out_keep", tag, i), ok, tab[i].e_keep);
                chk($sformatf("%s[%0d].out_last", tag, i), ol, tab[i].e_last);
            end
        end
    endtask

    // Reference model: words are built from whole beats by arithmetic, independent of any counter.
    task automatic run_random(input int sel, input string tag, input int nbeats);
        exp_t q[$];
        logic [31:0] part[$];
        exp_t e;
        logic pend, pl, ordy, done, prev_stall;
        logic [31:0] pd, mask, word;
        int sent;
        logic ir, ov, ol, bz, p_ol;
        logic [31:0] od, p_od;
        logic [3:0] ok, p_ok;
        pend = 1'b0; pl = 1'b0; pd = '0; sent = 0; done = 1'b0; prev_stall = 1'b0;
        p_od = '0; p_ok = '0; p_ol = 1'b0;
        mask = (sel == 0) ? 32'hFF : (sel == 1) ? 32'hFFFF_FFFF : 32'hFFFF;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            if (!pend && sent < nbeats && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                sent++;
                pd = $urandom & mask;
                pl = (sent == nbeats) || ($urandom_range(0, 5) == 0);
            end
            ordy = (sent == nbeats && !pend) ? 1'b1 : ($urandom_range(0, 2) != 0);
            drive(sel, pend, pend ? pd : ($urandom & mask), pl, ordy);
            #1;
            sample(sel, ir, ov, od, ok, ol, bz);
            chk({tag, ".out_valid"}, ov, q.size() != 0);
            chk({tag, ".busy"}, bz, (q.size() != 0) || (part.size() != 0));
            if (prev_stall) begin
                chk({tag, ".hold_valid"}, ov, 1'b1);
                chk({tag, ".hold_data"}, od, p_od);
                chk({tag, ".hold_keep"}, ok, p_ok);
                chk({tag, ".hold_last"}, ol, p_ol);
            end
            if (ov && ordy && q.size() != 0) begin
                chk({tag, ".out_data"}, od, q[0].data);
                chk({tag, ".out_keep"}, ok, q[0].keep);
                chk({tag, ".out_last"}, ol, q[0].last);
                void'(q.pop_front());
            end
            if (pend && ir) begin
                case (sel)
                    0: begin
                        part.push_back(pd);
                        if (part.size() == 4 || pl) begin
                            word = '0;
                            foreach (part[k]) word = word | (part[k] << (8 * k));
                            e.data = word;
                            e.keep = 4'((1 << part.size()) - 1);
                            e.last = pl;
                            q.push_back(e);
                            part.delete();
                        end
                    end
                    1: begin
                        for (int k = 0; k < 4; k++) begin
                            e.data = (pd >> (8 * k)) & 32'hFF;
                            e.keep = 4'h1;
                            e.last = pl && (k == 3);
                            q.push_back(e);
                        end
                    end
                    default: begin
                        e.data = pd; e.keep = 4'h1; e.last = pl;
                        q.push_back(e);
                    end
                endcase
                pend = 1'b0;
            end
            prev_stall = ov && !ordy;
            p_od = od; p_ok = ok; p_ol = ol;
            if (sent == nbeats && !pend && q.size() == 0 && part.size() == 0) done = 1'b1;
        end
        chk({tag, ".drained"}, done, 1'b1);
        @(negedge clk);
        drive(sel, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        sample(sel, ir, ov, od, ok, ol, bz);
        chk({tag, ".final_valid"}, ov, 1'b0);
        chk({tag, ".final_busy"}, bz, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ir, ov, ol, bz;
        logic [31:0] od;
        logic [3:0] ok;

        // UP 8->32: full word, short packet, backpressure with ignored input, single-beat packet.
        up_tab[0]  = mk(1, 32'h11, 0, 1,  1, 0, 32'h0,        4'h0, 0, 0);
        up_tab[1]  = mk(1, 32'h22, 0, 1,  1, 0, 32'h0,        4'h0, 0, 1);
        up_tab[2]  = mk(1, 32'h33, 0, 1,  1, 0, 32'h0,        4'h0, 0, 1);
        up_tab[3]  = mk(1, 32'h44, 1, 1,  1, 0, 32'h0,        4'h0, 0, 1);
        up_tab[4]  = mk(0, 32'h00, 0, 1,  1, 1, 32'h44332211, 4'hF, 1, 1);
        up_tab[5]  = mk(1, 32'hAA, 0, 1,  1, 0, 32'h0,        4'h0, 0, 0);
        up_tab[6]  = mk(1, 32'hBB, 1, 1,  1, 0, 32'h0,        4'h0, 0, 1);
        up_tab[7]  = mk(0, 32'h00, 0, 0,  0, 1, 32'h0000BBAA, 4'h3, 1, 1);
        up_tab[8]  = mk(1, 32'hCC, 1, 0,  0, 1, 32'h0000BBAA, 4'h3, 1, 1);
        up_tab[9]  = mk(1, 32'hCC, 1, 0,  0, 1, 32'h0000BBAA, 4'h3, 1, 1);
        up_tab[10] = mk(1, 32'hCC, 1, 1,  1, 1, 32'h0000BBAA, 4'h3, 1, 1);
        up_tab[11] = mk(0, 32'h00, 0, 0,  0, 1, 32'h000000CC, 4'h1, 1, 1);
        up_tab[12] = mk(0, 32'h00, 0, 1,  1, 1, 32'h000000CC, 4'h1, 1, 1);
        up_tab[13] = mk(0, 32'h00, 0, 1,  1, 0, 32'h0,        4'h0, 0, 0);

        // DOWN 32->8: LSB-first slices, back-to-back second word, stall mid-word.
        dn_tab[0]  = mk(1, 32'hDEADBEEF, 1, 1,  1, 0, 32'h0,  4'h0, 0, 0);
        dn_tab[1]  = mk(1, 32'h12345678, 0, 1,  0, 1, 32'hEF, 4'h1, 0, 1);
        dn_tab[2]  = mk(1, 32'h12345678, 0, 1,  0, 1, 32'hBE, 4'h1, 0, 1);
        dn_tab[3]  = mk(1, 32'h12345678, 0, 1,  0, 1, 32'hAD, 4'h1, 0, 1);
        dn_tab[4]  = mk(1, 32'h12345678, 0, 1,  1, 1, 32'hDE, 4'h1, 1, 1);
        dn_tab[5]  = mk(0, 32'h0,        0, 0,  0, 1, 32'h78, 4'h1, 0, 1);
        dn_tab[6]  = mk(0, 32'h0,        0, 0,  0, 1, 32'h78, 4'h1, 0, 1);
        dn_tab[7]  = mk(0, 32'h0,        0, 1,  0, 1, 32'h78, 4'h1, 0, 1);
        dn_tab[8]  = mk(0, 32'h0,        0, 1,  0, 1, 32'h56, 4'h1, 0, 1);
        dn_tab[9]  = mk(0, 32'h0,        0, 1,  0, 1, 32'h34, 4'h1, 0, 1);
        dn_tab[10] = mk(0, 32'h0,        0, 1,  1, 1, 32'h12, 4'h1, 0, 1);
        dn_tab[11] = mk(0, 32'h0,        0, 1,  1, 0, 32'h0,  4'h0, 0, 0);

        idle_all();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sample(s, ir, ov, od, ok, ol, bz);
            chk($sformatf("reset[%0d].in_ready", s), ir, 1'b0);
            chk($sformatf("reset[%0d].out_valid", s), ov, 1'b0);
            chk($sformatf("reset[%0d].out_data", s), od, 32'h0);
            chk($sformatf("reset[%0d].out_keep", s), ok, 4'h0);
            chk($sformatf("reset[%0d].out_last", s), ol, 1'b0);
            chk($sformatf("reset[%0d].busy", s), bz, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sample(s, ir, ov, od, ok, ol, bz);
            chk($sformatf("post_reset[%0d].in_ready", s), ir, 1'b1);
            chk($sformatf("post_reset[%0d].out_valid", s), ov, 1'b0);
        end

        run_table(0, "up_tab", up_tab);
        idle_all();
        run_table(1, "dn_tab", dn_tab);
        idle_all();

        // Reset in the middle of a word discards the partial beats.
        @(negedge clk); drive(0, 1'b1, 32'h01, 1'b0, 1'b1);
        @(negedge clk); drive(0, 1'b1, 32'h02, 1'b0, 1'b1);
        @(negedge clk); drive(0, 1'b0, 32'h00, 1'b0, 1'b1); rst = 1'b1;
        @(negedge clk); #1;
        sample(0, ir, ov, od, ok, ol, bz);
        chk("midrst.busy", bz, 1'b0);
        chk("midrst.out_valid", ov, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            sample(0, ir, ov, od, ok, ol, bz);
            chk("midrst.idle_valid", ov, 1'b0);
            chk("midrst.idle_busy", bz, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 1'b1, 32'hA1 + i, (i == 3), 1'b1);
        end
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        sample(0, ir, ov, od, ok, ol, bz);
        chk("midrst.word_valid", ov, 1'b1);
        chk("midrst.word_data", od, 32'hA4A3A2A1);
        chk("midrst.word_keep", ok, 4'hF);
        chk("midrst.word_last", ol, 1'b1);
        idle_all();

        run_random(0, "rnd_up", 200);
        idle_all();
        run_random(1, "rnd_dn", 100);
        idle_all();
        run_random(2, "rnd_ps", 200);
        idle_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
